// File: rtl/uart_rx.sv
// 8N1 serial receiver (16x oversampled, LSB first) feeding a first-word-fall-through byte FIFO.
// Latency: ~9.5 bit periods + 3 clocks from start edge to rx_valid_o; no backpressure, full FIFO drops and sets rx_ovf_o.
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       sys_clk_i,
  input  logic       sys_rstn_i,
  input  logic       uart_rx_i,
  input  logic       rx_rd_i,
  input  logic       rx_err_clr_i,
  output logic [7:0] rx_dat_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o,
  output logic       rx_ovf_o
);

  localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [32:0] C_INC   = 33'(16 * BAUD);
  localparam logic [32:0] C_CLK   = 33'(CLK_HZ);
  localparam logic [AW:0] C_DEPTH = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  logic [31:0]   r_acc;
  logic [3:0]    r_tcnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_ferr;
  logic          r_ovf;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;

  state_t        w_state_nxt;
  logic [31:0]   w_acc_nxt;
  logic [3:0]    w_tcnt_nxt;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_push;
  logic          w_ferr_set;
  logic          w_rxs;
  logic [32:0]   w_acc_sum;
  logic [31:0]   w_acc_diff;
  logic          w_tick;
  logic          w_full;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_ovf_set;

  // Two-flop synchronizer; reset high so a line held low across reset is not a start edge.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs      = r_sync2;
  assign w_acc_sum  = {1'b0, r_acc} + C_INC;
  assign w_acc_diff = w_acc_sum[31:0] - C_CLK[31:0];
  assign w_tick     = (r_state != S_IDLE) && (w_acc_sum >= C_CLK);

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = 32'd0;
    w_tcnt_nxt  = r_tcnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;

    // Accumulator and tick counter only run outside IDLE so the phase starts at the edge.
    if (r_state != S_IDLE) begin
      w_acc_nxt = w_tick ? w_acc_diff : w_acc_sum[31:0];
      if (w_tick) begin
        w_tcnt_nxt = r_tcnt + 4'd1;
      end
    end

    case (r_state)
      S_IDLE: begin
        w_tcnt_nxt = 4'd0;
        if (!w_rxs) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_tick && (r_tcnt == 4'd7)) begin
          if (!w_rxs) begin
            w_state_nxt = S_DATA;
            w_tcnt_nxt  = 4'd0;
            w_bit_nxt   = 3'd0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_tick && (r_tcnt == 4'd15)) begin
          w_shift_nxt = {w_rxs, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_tick && (r_tcnt == 4'd15)) begin
          if (w_rxs) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_set  = 1'b1;
            w_state_nxt = S_BRK;
          end
        end
      end
      S_BRK: begin
        if (w_rxs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      r_acc   <= 32'd0;
      r_tcnt  <= 4'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_full    = (r_cnt == C_DEPTH);
  assign w_pop     = rx_rd_i && (r_cnt != '0);
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  always_ff @(posedge sys_clk_i) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= r_shift;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW + 1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW + 1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      r_ferr <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_ferr_set) begin
        r_ferr <= 1'b1;
      end else if (rx_err_clr_i) begin
        r_ferr <= 1'b0;
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (rx_err_clr_i) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign rx_valid_o = (r_cnt != '0);
  assign rx_dat_o   = rx_valid_o ? r_mem[r_rptr] : 8'h00;
  assign rx_ferr_o  = r_ferr;
  assign rx_ovf_o   = r_ovf;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a reduced clock rate (86.8 clocks per bit) to keep runs short.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int unsigned CLK_HZ   = 10000000;
  localparam int unsigned BAUD     = 115200;
  localparam int unsigned DEPTH    = 4;
  localparam int          BIT_CLKS = 87;

  logic       sys_clk_i    = 1'b0;
  logic       sys_rstn_i   = 1'b0;
  logic       uart_rx_i    = 1'b1;
  logic       rx_rd_i      = 1'b0;
  logic       rx_err_clr_i = 1'b0;
  logic [7:0] rx_dat_o;
  logic       rx_valid_o;
  logic       rx_ferr_o;
  logic       rx_ovf_o;

  int checks = 0;
  int errors = 0;

  uart_rx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .sys_clk_i   (sys_clk_i),
    .sys_rstn_i  (sys_rstn_i),
    .uart_rx_i   (uart_rx_i),
    .rx_rd_i     (rx_rd_i),
    .rx_err_clr_i(rx_err_clr_i),
    .rx_dat_o    (rx_dat_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ferr_o   (rx_ferr_o),
    .rx_ovf_o    (rx_ovf_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  task automatic hold_line(input logic v, input int n);
    uart_rx_i = v;
    repeat (n) @(negedge sys_clk_i);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    hold_line(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold_line(d[i], BIT_CLKS);
    hold_line(stop_bit, BIT_CLKS);
    uart_rx_i = 1'b1;
  endtask

  task automatic pulse_rd();
    rx_rd_i = 1'b1;
    @(negedge sys_clk_i);
    rx_rd_i = 1'b0;
  endtask

  task automatic pulse_clr();
    rx_err_clr_i = 1'b1;
    @(negedge sys_clk_i);
    rx_err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    sys_rstn_i = 1'b0;
    repeat (3) @(negedge sys_clk_i);
    checks++;
    if ({rx_valid_o, rx_dat_o, rx_ferr_o, rx_ovf_o} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b dat=%02h ferr=%b ovf=%b, expected all 0",
               rx_valid_o, rx_dat_o, rx_ferr_o, rx_ovf_o);
    end
    sys_rstn_i = 1'b1;
    hold_line(1'b1, 20);
    checks++;
    if ({rx_valid_o, rx_ferr_o, rx_ovf_o} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_idle: valid=%b ferr=%b ovf=%b, expected 0 0 0",
               rx_valid_o, rx_ferr_o, rx_ovf_o);
    end
  endtask

  task automatic test_single();
    send_byte(8'h55, 1'b1);
    checks++;
    if (rx_valid_o !== 1'b1 || rx_dat_o !== 8'h55) begin
      errors++;
      $display("FAIL single_byte: valid=%b dat=%02h, expected valid=1 dat=55", rx_valid_o, rx_dat_o);
    end
    checks++;
    if (rx_ferr_o !== 1'b0 || rx_ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL single_flags: ferr=%b ovf=%b, expected 0 0", rx_ferr_o, rx_ovf_o);
    end
    pulse_rd();
    checks++;
    if (rx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: valid=%b, expected 0", rx_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'hA5; exp[1] = 8'h00; exp[2] = 8'hFF;
    for (int i = 0; i < 3; i++) send_byte(exp[i], 1'b1);
    hold_line(1'b1, 10);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_valid_o !== 1'b1 || rx_dat_o !== exp[i]) begin
        errors++;
        $display("FAIL b2b_order[%0d]: valid=%b dat=%02h, expected valid=1 dat=%02h",
                 i, rx_valid_o, rx_dat_o, exp[i]);
      end
      pulse_rd();
    end
    checks++;
    if (rx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: valid=%b, expected 0", rx_valid_o);
    end
  endtask

  task automatic test_framing();
    send_byte(8'h3C, 1'b0);
    hold_line(1'b0, 2 * BIT_CLKS);
    hold_line(1'b1, 2 * BIT_CLKS);
    checks++;
    if (rx_ferr_o !== 1'b1 || rx_valid_o !== 1'b0 || rx_ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL ferr_set: ferr=%b valid=%b ovf=%b, expected 1 0 0", rx_ferr_o, rx_valid_o, rx_ovf_o);
    end
    send_byte(8'h81, 1'b1);
    checks++;
    if (rx_valid_o !== 1'b1 || rx_dat_o !== 8'h81 || rx_ferr_o !== 1'b1) begin
      errors++;
      $display("FAIL ferr_next_byte: valid=%b dat=%02h ferr=%b, expected 1 81 1",
               rx_valid_o, rx_dat_o, rx_ferr_o);
    end
    pulse_rd();
    checks++;
    if (rx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ferr_only_one: valid=%b, expected 0", rx_valid_o);
    end
    pulse_clr();
    checks++;
    if (rx_ferr_o !== 1'b0) begin
      errors++;
      $display("FAIL ferr_clear: ferr=%b, expected 0", rx_ferr_o);
    end
  endtask

  task automatic test_glitch();
    // 20 clocks is well short of the half-bit start qualification point (~43 clocks).
    hold_line(1'b0, 20);
    hold_line(1'b1, 3 * BIT_CLKS);
    checks++;
    if ({rx_valid_o, rx_ferr_o, rx_ovf_o} !== 3'b000) begin
      errors++;
      $display("FAIL glitch_reject: valid=%b ferr=%b ovf=%b, expected 0 0 0",
               rx_valid_o, rx_ferr_o, rx_ovf_o);
    end
    send_byte(8'h96, 1'b1);
    checks++;
    if (rx_valid_o !== 1'b1 || rx_dat_o !== 8'h96) begin
      errors++;
      $display("FAIL glitch_recover: valid=%b dat=%02h, expected valid=1 dat=96", rx_valid_o, rx_dat_o);
    end
    pulse_rd();
  endtask

  task automatic test_overflow();
    bit seen;
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    hold_line(1'b1, 10);
    checks++;
    if (rx_ovf_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b, expected 1", rx_ovf_o);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (rx_valid_o !== 1'b1 || rx_dat_o !== 8'(i)) begin
        errors++;
        $display("FAIL ovf_contents[%0d]: valid=%b dat=%02h, expected valid=1 dat=%02h",
                 i, rx_valid_o, rx_dat_o, 8'(i));
      end
      pulse_rd();
    end
    checks++;
    if (rx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drained: valid=%b, expected 0", rx_valid_o);
    end
    pulse_clr();
    checks++;
    if (rx_ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b, expected 0", rx_ovf_o);
    end

    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    seen = 1'b0;
    fork
      send_byte(8'h05, 1'b1);
      begin
        for (int c = 0; c < 12 * BIT_CLKS; c++) begin
          @(negedge sys_clk_i);
          if (dut.w_push) begin
            seen = 1'b1;
            pulse_rd();
            break;
          end
        end
      end
    join
    hold_line(1'b1, 10);
    checks++;
    if (seen !== 1'b1 || rx_ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_push_pop: push_seen=%b ovf=%b, expected 1 0", seen, rx_ovf_o);
    end
    for (int i = 2; i <= 5; i++) begin
      checks++;
      if (rx_valid_o !== 1'b1 || rx_dat_o !== 8'(i)) begin
        errors++;
        $display("FAIL push_pop_contents[%0d]: valid=%b dat=%02h, expected valid=1 dat=%02h",
                 i, rx_valid_o, rx_dat_o, 8'(i));
      end
      pulse_rd();
    end
    checks++;
    if (rx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL push_pop_drained: valid=%b, expected 0", rx_valid_o);
    end
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h11, 1'b1);
    hold_line(1'b1, BIT_CLKS);
    fork
      send_byte(8'h7E, 1'b1);
      begin
        repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(negedge sys_clk_i);
        sys_rstn_i = 1'b0;
      end
    join
    checks++;
    if (rx_valid_o !== 1'b0 || rx_dat_o !== 8'h00) begin
      errors++;
      $display("FAIL midframe_flush: valid=%b dat=%02h, expected 0 00", rx_valid_o, rx_dat_o);
    end
    hold_line(1'b1, 5);
    sys_rstn_i = 1'b1;
    hold_line(1'b1, BIT_CLKS);
    send_byte(8'h42, 1'b1);
    checks++;
    if (rx_valid_o !== 1'b1 || rx_dat_o !== 8'h42 || rx_ferr_o !== 1'b0 || rx_ovf_o !== 1'b0) begin
      errors++;
      $display("FAIL midframe_recover: valid=%b dat=%02h ferr=%b ovf=%b, expected 1 42 0 0",
               rx_valid_o, rx_dat_o, rx_ferr_o, rx_ovf_o);
    end
    pulse_rd();
    checks++;
    if (rx_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL midframe_only_one: valid=%b, expected 0", rx_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_framing();
    test_glitch();
    test_overflow();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
